// File: rtl/grid_scan_display.sv
// Row-multiplexed LED matrix driver for the Game of Life grid: frame-boundary
// snapshot, per-row dwell with a leading blank, population count and still-life flag.
module grid_scan_display #(
  parameter int SIZE  = 7,
  parameter int DWELL = 1024,
  parameter int BLANK = 4
) (
  input  logic                 clka,
  input  logic                 rst_n,
  input  logic [1:0]           game_state,
  input  logic [SIZE*SIZE-1:0] grid,
  output logic [SIZE-1:0]      row_sel,
  output logic [SIZE-1:0]      col_data,
  output logic                 frame_start,
  output logic [5:0]           population,
  output logic                 stable
);

  localparam int CELLS = SIZE * SIZE;
  localparam int DW    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int RW    = (SIZE > 1) ? $clog2(SIZE) : 1;

  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [DW-1:0] BLANK_END  = DW'(BLANK);
  localparam logic [RW-1:0] ROW_LAST   = RW'(SIZE - 1);

  typedef enum logic [1:0] {
    GS_STOP    = 2'b00,
    GS_PROGRAM = 2'b01,
    GS_RUN     = 2'b10,
    GS_PAUSE   = 2'b11
  } game_state_e;

  logic [DW-1:0]    dwell_cnt;
  logic [RW-1:0]    row_idx;
  logic [CELLS-1:0] snapshot;
  logic [5:0]       pop_acc;
  logic             seen_boundary;

  logic             dwell_last;
  logic             row_last;
  logic             boundary;
  logic             lit;
  logic [SIZE-1:0]  cur_row;
  logic [SIZE-1:0]  row_onehot;

  function automatic logic [5:0] popcount(input logic [SIZE-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < SIZE; i++) n = n + 6'(v[i]);
    return n;
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    cur_row    = '0;
    row_onehot = '0;
    dwell_last = (dwell_cnt == DWELL_LAST);
    row_last   = (row_idx == ROW_LAST);
    boundary   = dwell_last && row_last;
    lit        = (dwell_cnt >= BLANK_END);
    for (int r = 0; r < SIZE; r++) begin
      if (row_idx == RW'(r)) begin
        cur_row       = snapshot[r*SIZE +: SIZE];
        row_onehot[r] = 1'b1;
      end
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      dwell_cnt <= '0;
      row_idx   <= '0;
    end else if (dwell_last) begin
      dwell_cnt <= '0;
      row_idx   <= row_last ? '0 : row_idx + 1'b1;
    end else begin
      dwell_cnt <= dwell_cnt + 1'b1;
    end
  end

  // The comparison for stable happens at capture time, so the retired
  // snapshot never needs to be held afterwards.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      snapshot      <= '0;
      pop_acc       <= '0;
      population    <= '0;
      stable        <= 1'b0;
      seen_boundary <= 1'b0;
    end else if (boundary) begin
      snapshot      <= grid;
      population    <= pop_acc;
      pop_acc       <= '0;
      stable        <= (grid == snapshot) && (game_state_e'(game_state) == GS_RUN);
      seen_boundary <= 1'b1;
    end else if (dwell_cnt == '0) begin
      pop_acc <= pop_acc + popcount(cur_row);
    end
  end

  // Display outputs lag the counters by one cycle; a row change always lands in the blank.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      row_sel     <= '0;
      col_data    <= '0;
      frame_start <= 1'b0;
    end else begin
      row_sel     <= lit ? row_onehot : '0;
      col_data    <= lit ? cur_row : '0;
      frame_start <= seen_boundary && (row_idx == '0) && (dwell_cnt == '0);
    end
  end

endmodule

// File: tb/tb_grid_scan_display.sv
// Self-checking bench for grid_scan_display: directed scenarios plus randomized
// grid/game_state traffic compared against a frame-level reference model.
module tb_grid_scan_display;

  localparam int SIZE  = 7;
  localparam int DWELL = 8;
  localparam int BLANK = 2;
  localparam int FRAME = SIZE * DWELL;

  localparam logic [1:0]  GS_RUN   = 2'b10;
  localparam logic [1:0]  GS_PAUSE = 2'b11;
  localparam logic [48:0] ALL_ONES = '1;

  logic        clka = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  game_state = GS_RUN;
  logic [48:0] grid = '0;
  logic [6:0]  row_sel;
  logic [6:0]  col_data;
  logic        frame_start;
  logic [5:0]  population;
  logic        stable;

  int checks = 0;
  int failures = 0;

  grid_scan_display #(.SIZE(SIZE), .DWELL(DWELL), .BLANK(BLANK)) dut (
    .clka        (clka),
    .rst_n       (rst_n),
    .game_state  (game_state),
    .grid        (grid),
    .row_sel     (row_sel),
    .col_data    (col_data),
    .frame_start (frame_start),
    .population  (population),
    .stable      (stable)
  );

  always #5 clka = ~clka;

  // Reference model: position inside the frame is derived from the number of
  // edges since reset; frame-level quantities change only at the last position.
  int          m_edges;
  int          m_pos;
  logic [48:0] m_snap;
  logic [6:0]  exp_row_sel;
  logic [6:0]  exp_col;
  logic        exp_fs;
  logic [5:0]  exp_pop;
  logic        exp_stable;

  assign m_pos = m_edges % FRAME;

  always @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      m_edges     <= 0;
      m_snap      <= '0;
      exp_row_sel <= '0;
      exp_col     <= '0;
      exp_fs      <= 1'b0;
      exp_pop     <= '0;
      exp_stable  <= 1'b0;
    end else begin
      exp_row_sel <= (m_pos % DWELL >= BLANK) ? 7'(1 << (m_pos / DWELL)) : 7'h00;
      exp_col     <= (m_pos % DWELL >= BLANK) ? 7'(m_snap >> ((m_pos / DWELL) * SIZE)) : 7'h00;
      exp_fs      <= (m_pos == 0) && (m_edges != 0);
      if (m_pos == FRAME - 1) begin
        m_snap     <= grid;
        exp_pop    <= 6'($countones(m_snap));
        exp_stable <= (grid == m_snap) && (game_state == GS_RUN);
      end
      m_edges <= m_edges + 1;
    end
  end

  task automatic do_reset(input logic [48:0] g, input logic [1:0] gs);
    @(negedge clka);
    rst_n      = 1'b0;
    grid       = g;
    game_state = gs;
    @(negedge clka);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int  k;
    bit  found;
    #1 rst_n = 1'b0;
    #2;
    checks++; if (row_sel !== 7'h00) begin failures++; $display("FAIL reset_row_sel: got %h expected 00", row_sel); end
    checks++; if (col_data !== 7'h00) begin failures++; $display("FAIL reset_col_data: got %h expected 00", col_data); end
    checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL reset_frame_start: got %b expected 0", frame_start); end
    checks++; if (population !== 6'd0) begin failures++; $display("FAIL reset_population: got %0d expected 0", population); end
    checks++; if (stable !== 1'b0) begin failures++; $display("FAIL reset_stable: got %b expected 0", stable); end
    @(negedge clka);
    grid       = ALL_ONES;
    game_state = GS_RUN;
    rst_n      = 1'b1;
    repeat (120) @(negedge clka);
    checks++; if (population !== 6'd49) begin failures++; $display("FAIL pre_pulse_population: got %0d expected 49", population); end
    checks++; if (stable !== 1'b1) begin failures++; $display("FAIL pre_pulse_stable: got %b expected 1", stable); end
    checks++; if (row_sel !== 7'h01) begin failures++; $display("FAIL pre_pulse_row_sel: got %h expected 01", row_sel); end
    checks++; if (col_data !== 7'h7F) begin failures++; $display("FAIL pre_pulse_col_data: got %h expected 7f", col_data); end
    @(posedge clka);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (row_sel !== 7'h00) begin failures++; $display("FAIL async_row_sel: got %h expected 00", row_sel); end
    checks++; if (col_data !== 7'h00) begin failures++; $display("FAIL async_col_data: got %h expected 00", col_data); end
    checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL async_frame_start: got %b expected 0", frame_start); end
    checks++; if (population !== 6'd0) begin failures++; $display("FAIL async_population: got %0d expected 0", population); end
    checks++; if (stable !== 1'b0) begin failures++; $display("FAIL async_stable: got %b expected 0", stable); end
    @(negedge clka);
    rst_n = 1'b1;
    k = 0;
    found = 1'b0;
    while (!found && k < 200) begin
      @(negedge clka);
      k++;
      if (frame_start === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found || k != FRAME + 1) begin
      failures++;
      $display("FAIL first_frame_start: got cycle %0d (found=%0b) expected cycle %0d", k, found, FRAME + 1);
    end
  endtask

  task automatic test_scan_order();
    int         pos;
    int         frame;
    int         pulses;
    logic [6:0] er;
    logic [6:0] ec;
    logic       ef;
    do_reset(ALL_ONES, GS_RUN);
    pulses = 0;
    for (int k = 1; k <= 3 * FRAME; k++) begin
      @(negedge clka);
      pos   = (k - 1) % FRAME;
      frame = (k - 1) / FRAME;
      er = (pos % DWELL >= BLANK) ? 7'(1 << (pos / DWELL)) : 7'h00;
      ec = (frame >= 1 && pos % DWELL >= BLANK) ? 7'h7F : 7'h00;
      ef = (frame >= 1 && pos == 0);
      if (frame_start === 1'b1) pulses++;
      checks++; if (row_sel !== er) begin failures++; $display("FAIL scan_row_sel k=%0d: got %h expected %h", k, row_sel, er); end
      checks++; if (col_data !== ec) begin failures++; $display("FAIL scan_col_data k=%0d: got %h expected %h", k, col_data, ec); end
      checks++; if (frame_start !== ef) begin failures++; $display("FAIL scan_frame_start k=%0d: got %b expected %b", k, frame_start, ef); end
    end
    checks++; if (pulses != 2) begin failures++; $display("FAIL scan_pulse_count: got %0d expected 2", pulses); end
  endtask

  task automatic test_tear_free();
    int         pos;
    logic [6:0] ec;
    do_reset(ALL_ONES, GS_RUN);
    for (int k = 1; k <= 3 * FRAME; k++) begin
      @(negedge clka);
      pos = (k - 1) % FRAME;
      ec  = ((k - 1) / FRAME == 1 && pos % DWELL >= BLANK) ? 7'h7F : 7'h00;
      checks++; if (col_data !== ec) begin failures++; $display("FAIL tear_col_data k=%0d: got %h expected %h", k, col_data, ec); end
      if (k == FRAME + FRAME / 2) grid = '0;
    end
  endtask

  task automatic test_population();
    logic [5:0] ep;
    do_reset(49'h1_0000_0000_0101, GS_RUN);
    for (int k = 1; k <= 5 * FRAME; k++) begin
      @(negedge clka);
      ep = (k < 2 * FRAME) ? 6'd0 : (k < 5 * FRAME) ? 6'd3 : 6'd49;
      checks++; if (population !== ep) begin failures++; $display("FAIL population k=%0d: got %0d expected %0d", k, population, ep); end
      if (k == 3 * FRAME) grid = ALL_ONES;
    end
  endtask

  task automatic test_stable();
    logic [48:0] g;
    logic        es;
    g = 49'({$urandom(), $urandom()}) | 49'h1;
    do_reset(g, GS_RUN);
    for (int k = 1; k <= 6 * FRAME; k++) begin
      @(negedge clka);
      es = (k >= 2 * FRAME && k < 3 * FRAME) || (k >= 4 * FRAME && k < 5 * FRAME) || (k >= 6 * FRAME);
      checks++; if (stable !== es) begin failures++; $display("FAIL stable k=%0d: got %b expected %b", k, stable, es); end
      if (k == 2 * FRAME) grid = grid ^ (49'h1 << 24);
      if (k == 4 * FRAME) game_state = GS_PAUSE;
      if (k == 5 * FRAME + 20) game_state = GS_RUN;
    end
    do_reset('0, GS_RUN);
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge clka);
      es = (k == FRAME);
      checks++; if (stable !== es) begin failures++; $display("FAIL stable_empty k=%0d: got %b expected %b", k, stable, es); end
    end
  endtask

  task automatic test_random();
    int rst_at;
    do_reset(49'({$urandom(), $urandom()}), GS_RUN);
    rst_at = $urandom_range(150, 300);
    for (int k = 1; k <= 8 * FRAME; k++) begin
      @(negedge clka);
      checks++; if (row_sel !== exp_row_sel) begin failures++; $display("FAIL rand_row_sel k=%0d: got %h expected %h", k, row_sel, exp_row_sel); end
      checks++; if (col_data !== exp_col) begin failures++; $display("FAIL rand_col_data k=%0d: got %h expected %h", k, col_data, exp_col); end
      checks++; if (frame_start !== exp_fs) begin failures++; $display("FAIL rand_frame_start k=%0d: got %b expected %b", k, frame_start, exp_fs); end
      checks++; if (population !== exp_pop) begin failures++; $display("FAIL rand_population k=%0d: got %0d expected %0d", k, population, exp_pop); end
      checks++; if (stable !== exp_stable) begin failures++; $display("FAIL rand_stable k=%0d: got %b expected %b", k, stable, exp_stable); end
      if ($urandom_range(0, 39) == 0) grid = 49'({$urandom(), $urandom()});
      if ($urandom_range(0, 59) == 0) game_state = 2'($urandom_range(0, 3));
      if (k == rst_at) begin
        @(posedge clka);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (row_sel !== exp_row_sel) begin failures++; $display("FAIL rand_pulse_row_sel: got %h expected %h", row_sel, exp_row_sel); end
        checks++; if (population !== exp_pop) begin failures++; $display("FAIL rand_pulse_population: got %0d expected %0d", population, exp_pop); end
        @(negedge clka);
        rst_n = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_tear_free();
    test_population();
    test_stable();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
